pool_layer_sequencer: RTL

- Sequences the second conv layer and the layer-3 ReLU/max-pool stage across all output channels of the layer.
- Per channel: raises the begin levels for conv_2 and relu_3, waits for conv write-complete and then pool complete, and checks the pooled-output count.
- Drops the begins for a gap so the pool stage returns to idle, then advances the channel select.
- Sits between the top-level network controller (start/done) and the conv_2/relu_3 pair.

---
 rtl/pool_layer_sequencer_if.sv | 33 +++
 rtl/pool_layer_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pool_layer_sequencer_if.sv
// pool_layer_sequencer_if: control bundle between the layer
// sequencer, the network controller and the conv_2/relu_3 pair.
interface pool_layer_sequencer_if #(
    parameter int CH_W = 3
);
    logic            start;
    logic            abort;
    logic            conv_2_write_complete;
    logic            relu_3_ready;
    logic            relu_3_complete;
    logic            conv_2_begin;
    logic            layer_3_relu_begin;
    logic [CH_W-1:0] ch_sel;
    logic            busy;
    logic            layer_done;
    logic            err_timeout;
    logic            err_count;
    logic [7:0]      ready_count;

    modport master (
        output start, abort,
        output conv_2_write_complete, relu_3_ready, relu_3_complete,
        input  conv_2_begin, layer_3_relu_begin, ch_sel, busy,
        input  layer_done, err_timeout, err_count, ready_count
    );

    modport slave (
        input  start, abort,
        input  conv_2_write_complete, relu_3_ready, relu_3_complete,
        output conv_2_begin, layer_3_relu_begin, ch_sel, busy,
        output layer_done, err_timeout, err_count, ready_count
    );
endinterface

// File: rtl/pool_layer_sequencer.sv
// pool_layer_sequencer: steps conv_2 / relu_3 through every output
// channel of the layer, flagging per-channel timeouts and count errors.
module pool_layer_sequencer #(
    parameter int NUM_CH       = 8,
    parameter int CH_W         = 3,
    parameter int POOL_OUTPUTS = 144,
    parameter int GAP_CYCLES   = 2,
    parameter int TIMEOUT      = 40000
) (
    input logic                   clk,
    input logic                   rst,
    pool_layer_sequencer_if.slave bus
);
    localparam logic [CH_W-1:0] CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [7:0]      POOL_CNT = 8'(POOL_OUTPUTS);
    localparam logic [7:0]      GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [15:0]     TO_LAST  = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, LAUNCH, WAIT_CONV, WAIT_POOL, GAP, DONE, ERROR
    } state_t;

    state_t          state, state_n;
    logic            ready_q, complete_q;
    logic            ready_rise, complete_rise;
    logic            counting, timeout_hit;
    logic [15:0]     timer, timer_n;
    logic [7:0]      gap_cnt, gap_n;
    logic [7:0]      count, count_n;
    logic [CH_W-1:0] ch, ch_n;
    logic            err_to, err_to_n;
    logic            err_cnt, err_cnt_n;
    logic            run, run_n;
    logic            busy, busy_n;
    logic            done;

    assign ready_rise    = bus.relu_3_ready & ~ready_q;
    assign complete_rise = bus.relu_3_complete & ~complete_q;
    assign counting      = (state == WAIT_CONV) || (state == WAIT_POOL);
    // the timer value about to be written is what gets compared,
    // so TIMEOUT cycles elapse from LAUNCH to the ERROR entry edge
    assign timeout_hit   = counting && ((timer + 16'd1) == TO_LAST);

    assign run_n  = (state_n == LAUNCH) || (state_n == WAIT_CONV) ||
                    (state_n == WAIT_POOL);
    assign busy_n = run_n || (state_n == GAP);

    // next-state, counters and sticky flags
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        gap_n     = gap_cnt;
        count_n   = count;
        ch_n      = ch;
        err_to_n  = err_to;
        err_cnt_n = err_cnt;
        if (counting) begin
            timer_n = timer + 16'd1;
            if (!bus.abort && ready_rise && count != 8'hFF) begin
                count_n = count + 8'd1;
            end
        end
        if (bus.abort) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE, ERROR: begin
                    if (bus.start) begin
                        state_n   = LAUNCH;
                        ch_n      = '0;
                        err_to_n  = 1'b0;
                        err_cnt_n = 1'b0;
                    end else if (state == DONE) begin
                        state_n = IDLE;
                    end
                end
                LAUNCH: begin
                    count_n = '0;
                    timer_n = '0;
                    state_n = WAIT_CONV;
                end
                WAIT_CONV, WAIT_POOL: begin
                    if (timeout_hit) begin
                        err_to_n = 1'b1;
                        state_n  = ERROR;
                    end else if (complete_rise) begin
                        gap_n   = '0;
                        state_n = GAP;
                    end else if (state == WAIT_CONV &&
                                 bus.conv_2_write_complete) begin
                        state_n = WAIT_POOL;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0 && count != POOL_CNT) begin
                        err_cnt_n = 1'b1;
                    end
                    if (gap_cnt == GAP_LAST) begin
                        if (ch == CH_LAST) begin
                            state_n = DONE;
                        end else begin
                            ch_n    = ch + 1'b1;
                            state_n = LAUNCH;
                        end
                    end else begin
                        gap_n = gap_cnt + 8'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            timer   <= '0;
            gap_cnt <= '0;
            count   <= '0;
            ch      <= '0;
            err_to  <= 1'b0;
            err_cnt <= 1'b0;
            run     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            gap_cnt <= gap_n;
            count   <= count_n;
            ch      <= ch_n;
            err_to  <= err_to_n;
            err_cnt <= err_cnt_n;
            run     <= run_n;
            busy    <= busy_n;
            done    <= (state_n == DONE);
        end
    end

    // previous-cycle copies for rise detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q    <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            ready_q    <= bus.relu_3_ready;
            complete_q <= bus.relu_3_complete;
        end
    end

    assign bus.conv_2_begin       = run;
    assign bus.layer_3_relu_begin = run;
    assign bus.ch_sel             = ch;
    assign bus.busy               = busy;
    assign bus.layer_done         = done;
    assign bus.err_timeout        = err_to;
    assign bus.err_count          = err_cnt;
    assign bus.ready_count        = count;
endmodule
